// File: rtl/mdio_generador.sv
// mdio_generador: management-side MDIO transmitter.
// Accepts a 32-bit frame word, derives MDC from CLK, shifts the frame out
// MSB-first and, on reads, releases the line and captures 16 data bits.
module mdio_generador #(
  parameter int DIV_HALF = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MDIO_START,
  input  logic [31:0] T_DATA,
  input  logic        MDIO_IN,
  output logic        MDC,
  output logic        MDIO_OUT,
  output logic        MDIO_OE,
  output logic        MDIO_DONE,
  output logic        DATA_RDY,
  output logic [15:0] RD_DATA
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [3:0] DIV_LAST = 4'(DIV_HALF - 1);

  state_t      state;
  state_t      state_next;
  logic [3:0]  div_cnt;
  logic [4:0]  bit_cnt;
  logic [31:0] shift_reg;
  logic [15:0] capture;
  logic        is_read;
  logic        pending;
  logic        div_wrap;
  logic        last_fall;
  logic        req_valid;
  logic        next_oe;

  assign div_wrap  = (div_cnt == DIV_LAST);
  assign last_fall = div_wrap && MDC && (bit_cnt == 5'd31);
  assign req_valid = MDIO_START && (T_DATA[31:30] == 2'b01) &&
                     ((T_DATA[29:28] == 2'b01) || (T_DATA[29:28] == 2'b10));
  // Reads stop driving from bit 14 on; the bit about to start is bit_cnt+1.
  assign next_oe   = !is_read || (bit_cnt < 5'd13);

  // State register; reset aborts any frame without a completion pulse.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode plus the one-cycle completion strobes.
  always_comb begin
    state_next = state;
    MDIO_DONE  = 1'b0;
    DATA_RDY   = 1'b0;
    case (state)
      IDLE:  if (pending) state_next = SHIFT;
      SHIFT: if (last_fall) state_next = DONE;
      DONE: begin
        MDIO_DONE  = 1'b1;
        DATA_RDY   = is_read;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch, MDC divider, bit counter, serialiser and read capture.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      MDC       <= 1'b0;
      MDIO_OUT  <= 1'b0;
      MDIO_OE   <= 1'b0;
      RD_DATA   <= 16'd0;
      div_cnt   <= 4'd0;
      bit_cnt   <= 5'd0;
      shift_reg <= 32'd0;
      capture   <= 16'd0;
      is_read   <= 1'b0;
      pending   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          MDC      <= 1'b0;
          MDIO_OUT <= 1'b0;
          MDIO_OE  <= 1'b0;
          div_cnt  <= 4'd0;
          bit_cnt  <= 5'd0;
          if (pending) begin
            pending  <= 1'b0;
            MDIO_OE  <= 1'b1;
            MDIO_OUT <= shift_reg[31];
          end else if (req_valid) begin
            pending   <= 1'b1;
            shift_reg <= T_DATA;
            is_read   <= T_DATA[29];
            capture   <= 16'd0;
          end
        end
        SHIFT: begin
          if (div_wrap) begin
            div_cnt <= 4'd0;
            MDC     <= ~MDC;
            if (!MDC) begin
              if (is_read && (bit_cnt >= 5'd16))
                capture <= {capture[14:0], MDIO_IN};
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd31) begin
                MDIO_OUT <= 1'b0;
                MDIO_OE  <= 1'b0;
                if (is_read) RD_DATA <= capture;
              end else begin
                shift_reg <= {shift_reg[30:0], 1'b0};
                MDIO_OE   <= next_oe;
                MDIO_OUT  <= next_oe & shift_reg[30];
              end
            end
          end else begin
            div_cnt <= div_cnt + 4'd1;
          end
        end
        DONE: begin
          MDC      <= 1'b0;
          MDIO_OUT <= 1'b0;
          MDIO_OE  <= 1'b0;
        end
        default: begin
          MDC      <= 1'b0;
          MDIO_OUT <= 1'b0;
          MDIO_OE  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_generador.sv
// tb_mdio_generador: drives frames into two transmitters (DIV_HALF=2 and 1)
// and compares the observed MDIO waveforms against a frame-level model.
module tb_mdio_generador;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [31:0] tdata = 32'd0;
  logic        mdio_in = 1'b0;

  logic        mdc_a, out_a, oe_a, done_a, rdy_a;
  logic [15:0] rd_a;
  logic        mdc_b, out_b, oe_b, done_b, rdy_b;
  logic [15:0] rd_b;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] model_rd [2];

  mdio_generador #(.DIV_HALF(2)) dut_a (
    .CLK(CLK), .RESET(RESET), .MDIO_START(start_a), .T_DATA(tdata),
    .MDIO_IN(mdio_in), .MDC(mdc_a), .MDIO_OUT(out_a), .MDIO_OE(oe_a),
    .MDIO_DONE(done_a), .DATA_RDY(rdy_a), .RD_DATA(rd_a)
  );

  mdio_generador #(.DIV_HALF(1)) dut_b (
    .CLK(CLK), .RESET(RESET), .MDIO_START(start_b), .T_DATA(tdata),
    .MDIO_IN(mdio_in), .MDC(mdc_b), .MDIO_OUT(out_b), .MDIO_OE(oe_b),
    .MDIO_DONE(done_b), .DATA_RDY(rdy_b), .RD_DATA(rd_b)
  );

  always #5 CLK = ~CLK;

  task automatic sample(input int sel, output logic mdc, output logic out,
                        output logic oe, output logic done, output logic rdy,
                        output logic [15:0] rd);
    if (sel == 0) begin
      mdc = mdc_a; out = out_a; oe = oe_a; done = done_a; rdy = rdy_a; rd = rd_a;
    end else begin
      mdc = mdc_b; out = out_b; oe = oe_b; done = done_b; rdy = rdy_b; rd = rd_b;
    end
  endtask

  task automatic drive_start(input int sel, input logic v);
    if (sel == 0) start_a = v;
    else          start_b = v;
  endtask

  // Runs one request and checks the whole frame against the model:
  // bit b of a valid frame appears at the b-th MDC rise, OE low from bit 14
  // on reads, DONE 1+64*D edges after the accepting edge.
  task automatic run_frame(input int sel, input logic [31:0] td,
                           input logic [15:0] rv, input bit restart_at5,
                           input string tag);
    int d, win, rises, first_rise, last_rise, high_cycles;
    int done_cnt, done_edge, rdy_cnt, idle_oe, early_rd;
    bit valid, rd_op, pulsed, rdy_at_done;
    logic [31:0] got_out, got_oe, exp_out, exp_oe;
    logic [15:0] old_rd;
    logic mdc, out, oe, done, rdy, prev_mdc;
    logic [15:0] rd;
    d = (sel == 0) ? 2 : 1;
    win = 2 + 64 * d;
    valid = (td[31:30] == 2'b01) && ((td[29:28] == 2'b01) || (td[29:28] == 2'b10));
    rd_op = valid && (td[29:28] == 2'b10);
    for (int b = 0; b < 32; b++) begin
      exp_oe[31-b]  = !rd_op || (b < 14);
      exp_out[31-b] = exp_oe[31-b] ? td[31-b] : 1'b0;
    end
    rises = 0; first_rise = -1; last_rise = -1; high_cycles = 0;
    done_cnt = 0; done_edge = -1; rdy_cnt = 0; idle_oe = 0; early_rd = 0;
    pulsed = 0; rdy_at_done = 0; got_out = '0; got_oe = '0; prev_mdc = 1'b0;
    old_rd = model_rd[sel];

    tdata = td;
    mdio_in = 1'($urandom());
    drive_start(sel, 1'b1);
    @(posedge CLK); #1;
    drive_start(sel, 1'b0);
    for (int e = 1; e <= win; e++) begin
      @(posedge CLK); #1;
      sample(sel, mdc, out, oe, done, rdy, rd);
      if (mdc && !prev_mdc) begin
        if (rises < 32) begin
          got_out[31-rises] = out;
          got_oe[31-rises]  = oe;
        end
        if (rises == 0) first_rise = e;
        last_rise = e;
        rises++;
      end
      if (mdc) high_cycles++;
      if (oe) idle_oe++;
      if (done) begin
        done_cnt++;
        done_edge = e;
        rdy_at_done = rdy;
      end
      if (rdy) rdy_cnt++;
      if ((e < 1 + 64 * d) && (rd !== old_rd)) early_rd++;
      prev_mdc = mdc;
      if ((rises >= 16) && (rises < 32)) mdio_in = rv[31-rises];
      else                               mdio_in = 1'($urandom());
      if (restart_at5 && !pulsed && (rises == 5) && !mdc) begin
        pulsed = 1;
        tdata = ~td;
        drive_start(sel, 1'b1);
      end else begin
        tdata = td;
        drive_start(sel, 1'b0);
      end
    end

    if (valid) begin
      checks++;
      if (rises !== 32) begin failures++; $display("[TB] FAIL %s rises: got %0d want 32", tag, rises); end
      checks++;
      if (got_out !== exp_out) begin failures++; $display("[TB] FAIL %s out_bits: got %h want %h", tag, got_out, exp_out); end
      checks++;
      if (got_oe !== exp_oe) begin failures++; $display("[TB] FAIL %s oe_bits: got %h want %h", tag, got_oe, exp_oe); end
      checks++;
      if (first_rise !== 1 + d) begin failures++; $display("[TB] FAIL %s first_rise: got %0d want %0d", tag, first_rise, 1 + d); end
      checks++;
      if (last_rise !== 1 + 63 * d) begin failures++; $display("[TB] FAIL %s last_rise: got %0d want %0d", tag, last_rise, 1 + 63 * d); end
      checks++;
      if (high_cycles !== 32 * d) begin failures++; $display("[TB] FAIL %s mdc_high: got %0d want %0d", tag, high_cycles, 32 * d); end
      checks++;
      if (done_cnt !== 1) begin failures++; $display("[TB] FAIL %s done_count: got %0d want 1", tag, done_cnt); end
      checks++;
      if (done_edge !== 1 + 64 * d) begin failures++; $display("[TB] FAIL %s done_edge: got %0d want %0d", tag, done_edge, 1 + 64 * d); end
      checks++;
      if (rdy_cnt !== (rd_op ? 1 : 0)) begin failures++; $display("[TB] FAIL %s rdy_count: got %0d want %0d", tag, rdy_cnt, rd_op ? 1 : 0); end
      checks++;
      if (rdy_at_done !== rd_op) begin failures++; $display("[TB] FAIL %s rdy_with_done: got %0d want %0d", tag, rdy_at_done, rd_op); end
    end else begin
      checks++;
      if (rises !== 0) begin failures++; $display("[TB] FAIL %s idle_mdc: got %0d rises want 0", tag, rises); end
      checks++;
      if (idle_oe !== 0) begin failures++; $display("[TB] FAIL %s idle_oe: got %0d cycles want 0", tag, idle_oe); end
      checks++;
      if (done_cnt !== 0) begin failures++; $display("[TB] FAIL %s idle_done: got %0d want 0", tag, done_cnt); end
    end
    checks++;
    if (early_rd !== 0) begin failures++; $display("[TB] FAIL %s rd_mid_frame: got %0d changes want 0", tag, early_rd); end
    if (rd_op) model_rd[sel] = rv;
    checks++;
    if (rd !== model_rd[sel]) begin failures++; $display("[TB] FAIL %s rd_data: got %h want %h", tag, rd, model_rd[sel]); end
  endtask

  // Reset value of every output on both instances.
  task automatic test_reset;
    logic mdc, out, oe, done, rdy;
    logic [15:0] rd;
    RESET = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    for (int s = 0; s < 2; s++) begin
      sample(s, mdc, out, oe, done, rdy, rd);
      checks++;
      if ({mdc, out, oe, done, rdy, rd} !== 21'd0) begin
        failures++;
        $display("[TB] FAIL reset_outputs[%0d]: got %b_%h want all zero", s, {mdc, out, oe, done, rdy}, rd);
      end
    end
    model_rd[0] = 16'd0;
    model_rd[1] = 16'd0;
    RESET = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_write;
    run_frame(0, 32'h5A3C_F00D, 16'h0000, 0, "write");
  endtask

  task automatic test_read;
    run_frame(0, 32'h6842_0000, 16'hBEEF, 0, "read");
    run_frame(0, 32'h5123_4567, 16'h0000, 0, "write_after_read");
  endtask

  task automatic test_invalid;
    run_frame(0, 32'h1A3C_F00D, 16'h0000, 0, "invalid_st");
    run_frame(0, 32'h7000_0000, 16'h0000, 0, "invalid_op");
  endtask

  task automatic test_restart;
    run_frame(0, 32'h5555_A5C3, 16'h0000, 1, "restart_ignored");
  endtask

  // Asynchronous reset in the high half of read bit 20.
  task automatic test_reset_mid;
    int rises, done_seen;
    bit hit;
    logic mdc, out, oe, done, rdy, prev_mdc;
    logic [15:0] rd;
    rises = 0; hit = 0; prev_mdc = 1'b0; done_seen = 0;
    tdata = 32'h6842_0000;
    start_a = 1'b1;
    @(posedge CLK); #1;
    start_a = 1'b0;
    for (int e = 1; e <= 200 && !hit; e++) begin
      @(posedge CLK); #1;
      sample(0, mdc, out, oe, done, rdy, rd);
      if (mdc && !prev_mdc) rises++;
      prev_mdc = mdc;
      mdio_in = 1'($urandom());
      if ((rises == 21) && mdc) hit = 1;
    end
    checks++;
    if (!hit) begin failures++; $display("[TB] FAIL reset_mid_reach_bit20: got %0d rises want 21", rises); end
    #2;
    RESET = 1'b0;
    #1;
    sample(0, mdc, out, oe, done, rdy, rd);
    checks++;
    if ({mdc, out, oe, done, rdy, rd} !== 21'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid_outputs: got %b_%h want all zero", {mdc, out, oe, done, rdy}, rd);
    end
    model_rd[0] = 16'd0;
    model_rd[1] = 16'd0;
    for (int e = 0; e < 4; e++) begin
      @(posedge CLK); #1;
      sample(0, mdc, out, oe, done, rdy, rd);
      if (done) done_seen++;
    end
    RESET = 1'b1;
    for (int e = 0; e < 4; e++) begin
      @(posedge CLK); #1;
      sample(0, mdc, out, oe, done, rdy, rd);
      if (done) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin failures++; $display("[TB] FAIL reset_mid_no_done: got %0d want 0", done_seen); end
    run_frame(0, 32'h6A5A_0000, 16'h3C96, 0, "read_after_reset");
  endtask

  task automatic test_back_to_back;
    run_frame(1, 32'h57E2_A1B4, 16'h0000, 0, "b2b_write");
    run_frame(1, 32'h6BFF_FFFF, 16'h1234, 0, "b2b_read");
  endtask

  task automatic test_random;
    logic [31:0] r;
    logic [1:0]  op, st;
    int          k;
    for (int i = 0; i < 10; i++) begin
      r  = $urandom();
      k  = $urandom_range(0, 5);
      op = (k < 3) ? 2'b01 : ((k < 5) ? 2'b10 : 2'b11);
      st = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'b01;
      run_frame($urandom_range(0, 1), {st, op, r[27:0]}, 16'($urandom()), 0, "random");
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset;
    test_write;
    test_read;
    test_invalid;
    test_restart;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
